// File: rtl/fft_pkg.sv
// Shared definitions for the variable-point streaming FFT.
//   FFT_DW / FFT_MAX_LOG2_D : default component width and maximum butterfly span (log2)
//   r2sdf_state_e           : butterfly stage FSM states
//   cpack / cre / cim       : complex word pack/unpack at the default width, {re, im}
//   halve                   : the /2 used by the butterfly; rounding selected by R2SDF_ROUND_EN
// Optional feature macro: R2SDF_ROUND_EN (round-half-up halving instead of floor).
package fft_pkg;

    localparam int unsigned FFT_DW         = 17;
    localparam int unsigned FFT_MAX_LOG2_D = 5;

    typedef enum logic [1:0] {
        StRunA,
        StRunB,
        StDrain
    } r2sdf_state_e;

    function automatic logic [2*FFT_DW-1:0] cpack(input logic [FFT_DW-1:0] re,
                                                  input logic [FFT_DW-1:0] im);
        return {re, im};
    endfunction

    function automatic logic [FFT_DW-1:0] cre(input logic [2*FFT_DW-1:0] c);
        return c[2*FFT_DW-1:FFT_DW];
    endfunction

    function automatic logic [FFT_DW-1:0] cim(input logic [2*FFT_DW-1:0] c);
        return c[FFT_DW-1:0];
    endfunction

    // Operates on a wide signed value so any stage width can use it; callers truncate.
    function automatic logic signed [63:0] halve(input logic signed [63:0] x);
`ifdef R2SDF_ROUND_EN
        return (x + 64'sd1) >>> 1;
`else
        return x >>> 1;
`endif
    endfunction

endpackage

// File: rtl/r2sdf_delay.sv
// Circular delay line for the SDF feedback path.
//   clk, rst_n : clock, synchronous active-low reset (pointer only; storage is not cleared)
//   en         : step enable; advances the pointer and writes wr_data
//   log2_len   : active length is 2^log2_len entries; pointer wraps at that length
//   wr_data    : word written at the current pointer on a step
//   rd_data    : word stored at the current pointer (read-before-write)
module r2sdf_delay #(
    parameter int unsigned WIDTH        = 34,
    parameter int unsigned MAX_LOG2_LEN = 5,
    localparam int unsigned CW          = $clog2(MAX_LOG2_LEN + 1),
    localparam int unsigned AW          = (MAX_LOG2_LEN > 0) ? MAX_LOG2_LEN : 1,
    localparam int unsigned LW          = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CW-1:0]    log2_len,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2**AW];
    logic [AW-1:0]    ptr_q;
    logic [LW-1:0]    len_m1;
    logic             ptr_last;

    assign len_m1   = (LW'(1) << log2_len) - LW'(1);
    assign ptr_last = ({1'b0, ptr_q} == len_m1);
    assign rd_data  = mem[ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= ptr_last ? '0 : ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with run-time span D = 2^cfg_log2_d.
//   clk, rst_n  : clock, synchronous active-low reset
//   cfg_log2_d  : span select, clamped to MAX_LOG2_D, latched only while the stage is empty
//   in_valid    : sample present;  in_ready : sample accepted (low while draining)
//   in_data     : complex input {re, im}
//   flush       : drain pending differences (honoured only at cnt=0 with pending set)
//   out_valid   : out_data valid;  out_data : complex output scaled by 1/2
//   out_sum     : 1 = sum half (a+b)/2, 0 = difference half (a-b)/2
// Optional feature macro: R2SDF_ROUND_EN selects round-half-up halving (see fft_pkg::halve).
module r2sdf_stage
    import fft_pkg::*;
#(
    parameter int unsigned DW         = FFT_DW,
    parameter int unsigned MAX_LOG2_D = FFT_MAX_LOG2_D,
    localparam int unsigned CW        = $clog2(MAX_LOG2_D + 1),
    localparam int unsigned LW        = MAX_LOG2_D + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CW-1:0]   cfg_log2_d,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] in_data,
    input  logic            flush,
    output logic            out_valid,
    output logic [2*DW-1:0] out_data,
    output logic            out_sum
);

    function automatic logic [DW-1:0] half(input logic signed [DW:0] x);
        return DW'(halve(64'(x)));
    endfunction

    r2sdf_state_e   state_q;
    logic [LW-1:0]  cnt_q;
    logic           pending_q;
    logic [CW-1:0]  log2_d_q;

    logic [CW-1:0]  cfg_clamp;
    logic [CW-1:0]  log2_d;
    logic [LW-1:0]  d_len;
    logic [LW-1:0]  d_last;
    logic           empty;
    logic           flush_take;
    logic           draining;
    logic           step;

    logic [2*DW-1:0]     rd_data;
    logic [2*DW-1:0]     wr_data;
    logic signed [DW:0]  sum_re, sum_im, dif_re, dif_im;

    assign cfg_clamp = (cfg_log2_d > CW'(MAX_LOG2_D)) ? CW'(MAX_LOG2_D) : cfg_log2_d;
    assign empty     = (cnt_q == '0) && !pending_q;
    // While empty the live cfg applies immediately, so the first step of a frame uses it.
    assign log2_d    = empty ? cfg_clamp : log2_d_q;
    assign d_len     = LW'(1) << log2_d;
    assign d_last    = d_len - LW'(1);

    // The flush-accept cycle is itself the first drain step, so the input is held off then too.
    assign flush_take = (state_q == StRunA) && flush && (cnt_q == '0) && pending_q;
    assign draining   = (state_q == StDrain) || flush_take;
    assign in_ready   = !draining;
    assign step       = draining || in_valid;

    // a = stored sample (read value), b = incoming sample
    assign sum_re = {rd_data[2*DW-1], rd_data[2*DW-1:DW]} + {in_data[2*DW-1], in_data[2*DW-1:DW]};
    assign sum_im = {rd_data[DW-1], rd_data[DW-1:0]} + {in_data[DW-1], in_data[DW-1:0]};
    assign dif_re = {rd_data[2*DW-1], rd_data[2*DW-1:DW]} - {in_data[2*DW-1], in_data[2*DW-1:DW]};
    assign dif_im = {rd_data[DW-1], rd_data[DW-1:0]} - {in_data[DW-1], in_data[DW-1:0]};

    assign wr_data = draining            ? '0 :
                     (state_q == StRunB) ? {half(dif_re), half(dif_im)} : in_data;

    r2sdf_delay #(
        .WIDTH        (2 * DW),
        .MAX_LOG2_LEN (MAX_LOG2_D)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (step),
        .log2_len (log2_d),
        .wr_data  (wr_data),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StRunA;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            log2_d_q  <= cfg_clamp;
            out_valid <= 1'b0;
            out_sum   <= 1'b0;
            out_data  <= '0;
        end else begin
            log2_d_q  <= log2_d;
            out_valid <= 1'b0;
            if (step) begin
                unique case (state_q)
                    StRunA: begin
                        if (flush_take) begin
                            out_valid <= 1'b1;
                            out_sum   <= 1'b0;
                            out_data  <= rd_data;
                            if (d_len == LW'(1)) begin
                                pending_q <= 1'b0;
                            end else begin
                                state_q <= StDrain;
                                cnt_q   <= LW'(1);
                            end
                        end else begin
                            if (pending_q) begin
                                out_valid <= 1'b1;
                                out_sum   <= 1'b0;
                                out_data  <= rd_data;
                            end
                            cnt_q <= cnt_q + LW'(1);
                            if (cnt_q == d_last) begin
                                state_q <= StRunB;
                            end
                        end
                    end
                    StRunB: begin
                        out_valid <= 1'b1;
                        out_sum   <= 1'b1;
                        out_data  <= {half(sum_re), half(sum_im)};
                        if ((cnt_q - d_len) == d_last) begin
                            cnt_q     <= '0;
                            pending_q <= 1'b1;
                            state_q   <= StRunA;
                        end else begin
                            cnt_q <= cnt_q + LW'(1);
                        end
                    end
                    StDrain: begin
                        out_valid <= 1'b1;
                        out_sum   <= 1'b0;
                        out_data  <= rd_data;
                        if (cnt_q == d_last) begin
                            cnt_q     <= '0;
                            pending_q <= 1'b0;
                            state_q   <= StRunA;
                        end else begin
                            cnt_q <= cnt_q + LW'(1);
                        end
                    end
                    default: state_q <= StRunA;
                endcase
            end
        end
    end

endmodule

// File: doc/r2sdf_stage.md
# r2sdf_stage

Parametrised radix-2 single-path delay-feedback (SDF) butterfly stage for the variable-point streaming FFT. It replaces the fixed, fully parallel 64-point butterfly with a sequential stage: one complex sample in and one complex sample out per accepted step. The butterfly span D = 2^cfg_log2_d is programmable at run time, so one stage serves any point count up to 2·2^MAX_LOG2_D. Stages are cascaded, with twiddle multiplication between them handled externally.

## Interface
- DW, 17: bits per real/imag component; a complex word is 2·DW bits, packed {re, im} with re in the upper half.
- MAX_LOG2_D, 5: log2 of maximum delay (32, i.e. 64-point first stage).
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_log2_d  in  $clog2(MAX_LOG2_D+1)  span select, D = 2^cfg_log2_d; values > MAX_LOG2_D clamp to MAX_LOG2_D.
- in_valid  in  1  sample present.
- in_ready  out  1  stage accepts a sample (low only during DRAIN).
- in_data  in  2·DW  input complex sample.
- flush  in  1  request to drain pending differences.
- out_valid  out  1  out_data valid this cycle.
- out_data  out  2·DW  output complex sample, scaled by 1/2.
- out_sum  out  1  1 = sum half (a+b), 0 = difference half (a−b).

## Operation
- A step occurs on in_valid && in_ready (RUN), or on each DRAIN cycle (internal zero input). Without a step, all state holds.
- Counter cnt counts steps modulo 2D. The circular delay line has D active entries; each step reads and writes the same pointer address (read-before-write), and the pointer wraps at D.
- State RUN_A (cnt < D): write in_data to the delay line. If pending=1, emit the read value as a difference (out_sum=0). If pending=0, emit nothing.
- State RUN_B (cnt ≥ D): a = read value, b = in_data. Emit (a+b)/2 with out_sum=1, and write (a−b)/2 to the delay line. At cnt = 2D−1, set pending=1 and wrap cnt to 0 (back to RUN_A).
- DRAIN: entered from RUN_A when flush=1, cnt=0 and pending=1. The stage emits D stored differences on consecutive cycles with in_ready=0, then clears pending and returns to RUN_A with cnt=0.
- flush is ignored when cnt≠0 or pending=0. It is not queued.
- cfg_log2_d is latched only when cnt=0 and pending=0 (stage empty). Changes at other times take effect at the next empty point. To change D on a streaming stage, flush it first.
- Arithmetic: form a±b per component at DW+1 bits, then arithmetic right shift by 1 back to DW bits. Both halves are scaled, so no overflow or saturation is possible.

## Timing
- Registered outputs; an output produced by a step at cycle t is visible at cycle t+1.
- The first valid output after the empty state comes D steps after the first input.
- Continuous streaming: after the first D steps, out_valid follows the input steps one-to-one.
- Reset: cnt, pointer, pending, out_valid and out_sum are 0; out_data is 0; in_ready is 1; state is RUN_A; the latched cfg takes the current cfg_log2_d. Delay-line contents are not cleared; they are don't-care because pending=0.
- Reset mid-frame or mid-drain aborts immediately. Nothing further is emitted.
- D=1 (cfg=0): phases alternate each step; a flush drains in 1 cycle.

## Configuration
- R2SDF_ROUND_EN defined: the /2 uses round-half-up, (x+1)>>>1.
- Not defined: the /2 truncates toward −∞, x>>>1.
- Neither variant can overflow DW bits.

## Structure
- fft_pkg: DW and MAX_LOG2_D defaults, the state enum {RUN_A, RUN_B, DRAIN}, complex pack/unpack functions, and the halving function (macro-dependent).
- Sub-module r2sdf_delay: a circular buffer of 2^MAX_LOG2_D × 2·DW bits, with an active length input, a step enable, and same-address read/write.
- r2sdf_stage holds the counter, FSM, butterfly arithmetic and output registers.

## Test plan
- DW=17, cfg=1: re inputs 10, 20, 30, 40 (im 0) as consecutive steps, then flush.
  - Outputs: 20, 30 (out_sum=1), then −10, −10 (out_sum=0).
  - in_ready is low for exactly 2 cycles.
- Continuous two frames at cfg=1 (10, 20, 30, 40, 50, 60, 70, 80).
  - Frame-2 RUN_A outputs are −10, −10, followed by 60, 70.
  - No gaps in out_valid after the first 2 steps.
- Rounding with a=3, b=0 and with a=−3, b=0:
  - Macro off: sums 1 and −2.
  - R2SDF_ROUND_EN: sums 2 and −1.
- Stalls: in_valid toggled randomly with cfg=5 and 64 random samples.
  - Output equals the 2-point-butterfly reference model at spacing 32.
  - State holds during stalls.
- cfg change:
  - Change cfg 1→2 while pending=1: no effect until after flush.
  - After flush, a 4-sample span applies.
- Reset asserted at cnt=3 (cfg=2):
  - Next cycle all outputs are 0 and pending=0.
  - A new frame starts cleanly with no stale differences.
